controllo_multiciclo: RTL and testbench
=======================================

CONTROLLO_MULTICICLO -- requirements
Module: controllo_multiciclo

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 Cond  in  4  instruction condition field [31:28].
REQ-005 Op  in  2  instruction class [27:26]: 00 data-processing, 01 memory, 10 branch, 11 undefined.
REQ-006 Funct  in  6  instruction [25:20]; bit5 = I (immediate), bit0 = S (DP) or L (memory).
REQ-007 Rd  in  4  destination register [15:12].
REQ-008 ALUFlags  in  4  {N,Z,C,V} from ALU, valid in the current cycle.
REQ-009 PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA  out  1 each  datapath enables/selects.
REQ-010 ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl  out  2 each  datapath selects.

Function
REQ-011 The FSM SHALL have states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH.
REQ-012 Transitions SHALL be: FETCH->DECODE; DECODE->MEMADR (Op=01), EXECUTEI (Op=00, I=1), EXECUTER (Op=00, I=0), BRANCH (Op=10), FETCH (Op=11); MEMADR->MEMRD (L=1) else MEMWR; MEMRD->MEMWB; EXECUTER/EXECUTEI->ALUWB; MEMWB, MEMWR, ALUWB, BRANCH->FETCH.
REQ-013 Per-state outputs (all unlisted outputs 0): FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, NextPC=1; DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10; MEMADR: ALUSrcB=01; MEMRD, MEMWR: AdrSrc=1, ResultSrc=00; MEMWB: ResultSrc=01, RegW=1; EXECUTER: ALUSrcB=00, ALUOp=1; EXECUTEI: ALUSrcB=01, ALUOp=1; ALUWB: ResultSrc=00, RegW=1; MEMWR: MemW=1; BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
REQ-014 ALU decode when ALUOp=1: Funct[4:1] 0100->ALUControl 00 (ADD), 0010->01 (SUB), 0000->10 (AND), 1100->11 (ORR), any other->00 with FlagW=00; when ALUOp=0, ALUControl=00.
REQ-015 FlagW[1]=S for any decoded DP op; FlagW[0]=S only for ADD/SUB; FlagW=00 outside EXECUTER/EXECUTEI.
REQ-016 ImmSrc SHALL equal Op; RegSrc[0]=(Op==10); RegSrc[1]=(Op==01); both combinational from inputs in every state.
REQ-017 PCS SHALL be (RegW and Rd==1111) or Branch.
REQ-018 CondEx SHALL be computed combinationally from Cond and the stored flags: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE per ARM encoding 0000..1101; 1110 and 1111 always true.
REQ-019 Outputs: PCWrite = NextPC or (PCS and CondEx); RegWrite = RegW and CondEx; MemWrite = MemW and CondEx; IRWrite not gated.
REQ-020 Flag register: at the clock edge ending EXECUTER/EXECUTEI, N,Z update from ALUFlags when FlagW[1] and CondEx; C,V update when FlagW[0] and CondEx; otherwise hold.
REQ-021 Flags updated in a cycle SHALL affect CondEx from the next cycle only (the writing instruction is judged on the old flags).
REQ-022 A failed condition SHALL NOT alter the state sequence; the instruction completes its states with writes suppressed.
REQ-023 Undefined Op=11 SHALL cost exactly two cycles (FETCH, DECODE) with no RegWrite/MemWrite/flag change.

Reset
REQ-024 rst_n low SHALL immediately force state FETCH and flags {N,Z,C,V}=0000, regardless of clk, including mid-instruction.
REQ-025 While rst_n is low, outputs SHALL be the FETCH decode but PCWrite, IRWrite, RegWrite, MemWrite SHALL be 0.
REQ-026 First rising edge after rst_n rises SHALL execute FETCH.

Structure
REQ-027 State encoding, Op codes, ALUControl codes and Cond codes SHALL live in a shared package (pkg_controllo).
REQ-028 Flag register plus CondEx evaluation SHALL be one sub-module, logica_condizioni; FSM and decoders stay in the top.

Verification
REQ-029 Reset mid-MEMWR (rst_n low 3 ns off-edge) -> state FETCH asynchronously, MemWrite=0, flags 0000.
REQ-030 ADD-with-S, I=0, Cond=1110, ALUFlags=0100 -> FETCH,DECODE,EXECUTER,ALUWB; RegWrite=1 in ALUWB; Z=1 afterwards.
REQ-031 Next instr Cond=0001 (NE), Op=01, L=0 -> MEMWR reached, MemWrite=0; then Cond=0000 (EQ) store -> MemWrite=1.
REQ-032 LDR Rd=1111, Cond=1110 -> 5 cycles; PCWrite=1 in FETCH and MEMWB, RegWrite=1 in MEMWB.
REQ-033 SUBS Cond=1011 (LT) with N=1,V=0 stored, ALUFlags=0010 -> flags update to 0010 (judged on old flags).
REQ-034 Op=11 -> DECODE then FETCH; Branch Cond=1100 with Z=1 -> BRANCH state, PCWrite=0.

Source files
------------

// File: rtl/controllo_multiciclo_pkg.sv
// Shared definitions for the multicycle controller: FSM states, instruction
// class codes, ALU operation codes, condition codes and the condition check.
package pkg_controllo;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  // Instruction class (Op field)
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_UND = 2'b11;

  // ALUControl encodings
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  // Data-processing command field Funct[4:1]
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  // Condition field encodings
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;

  // Evaluate an ARM condition code against flags packed as {N,Z,C,V}
  function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    {n, z, c, v} = flags;
    case (cond)
      COND_EQ: cond_check = z;
      COND_NE: cond_check = ~z;
      COND_CS: cond_check = c;
      COND_CC: cond_check = ~c;
      COND_MI: cond_check = n;
      COND_PL: cond_check = ~n;
      COND_VS: cond_check = v;
      COND_VC: cond_check = ~v;
      COND_HI: cond_check = c & ~z;
      COND_LS: cond_check = ~c | z;
      COND_GE: cond_check = (n == v);
      COND_LT: cond_check = (n != v);
      COND_GT: cond_check = ~z & (n == v);
      COND_LE: cond_check = z | (n != v);
      default: cond_check = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/controllo_multiciclo_condizioni.sv
// Stored {N,Z,C,V} flags and condition evaluation. The condition is judged on
// the registered flags, so a flag write only becomes visible the next cycle.
module logica_condizioni
  import pkg_controllo::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_w,
  output logic       cond_ex
);

  logic [3:0] flags;

  assign cond_ex = cond_check(cond, flags);

  // N,Z and C,V are written independently, only when the instruction executes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= 4'b0000;
    end else begin
      if (flag_w[1] && cond_ex) flags[3:2] <= alu_flags[3:2];
      if (flag_w[0] && cond_ex) flags[1:0] <= alu_flags[1:0];
    end
  end

endmodule

// File: rtl/controllo_multiciclo.sv
// Multicycle controller: main FSM, ALU decoder and datapath control, with the
// architectural writes gated by the condition unit.
module controllo_multiciclo
  import pkg_controllo::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl
);

  state_t     state, state_next;
  logic       next_pc, ir_write, adr_src, alu_src_a;
  logic       reg_w, mem_w, alu_op, branch;
  logic [1:0] result_src, alu_src_b;
  logic [1:0] flag_w;
  logic       cond_ex;
  logic       pcs;

  // State register; reset lands in FETCH without waiting for a clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_next;
  end

  // Next-state logic; the sequence never depends on the condition outcome
  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_MEM:  state_next = S_MEMADR;
          OP_DP:   state_next = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          OP_BR:   state_next = S_BRANCH;
          default: state_next = S_FETCH;
        endcase
      end
      S_MEMADR:   state_next = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:    state_next = S_MEMWB;
      S_EXECUTER: state_next = S_ALUWB;
      S_EXECUTEI: state_next = S_ALUWB;
      default:    state_next = S_FETCH;
    endcase
  end

  // Per-state control outputs before condition gating
  always_comb begin
    next_pc    = 1'b0;
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    alu_op     = 1'b0;
    branch     = 1'b0;
    case (state)
      S_FETCH: begin
        ir_write   = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        next_pc    = 1'b1;
      end
      S_DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      S_MEMADR:   alu_src_b = 2'b01;
      S_MEMRD:    adr_src   = 1'b1;
      S_MEMWR: begin
        adr_src = 1'b1;
        mem_w   = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_w      = 1'b1;
      end
      S_EXECUTER: alu_op = 1'b1;
      S_EXECUTEI: begin
        alu_src_b = 2'b01;
        alu_op    = 1'b1;
      end
      S_ALUWB:    reg_w = 1'b1;
      S_BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        branch     = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU decoder; unrecognised commands fall back to ADD and leave flags alone
  always_comb begin
    ALUControl = ALU_ADD;
    flag_w     = 2'b00;
    if (alu_op) begin
      case (Funct[4:1])
        CMD_ADD: begin ALUControl = ALU_ADD; flag_w = {Funct[0], Funct[0]}; end
        CMD_SUB: begin ALUControl = ALU_SUB; flag_w = {Funct[0], Funct[0]}; end
        CMD_AND: begin ALUControl = ALU_AND; flag_w = {Funct[0], 1'b0};     end
        CMD_ORR: begin ALUControl = ALU_ORR; flag_w = {Funct[0], 1'b0};     end
        default: begin ALUControl = ALU_ADD; flag_w = 2'b00;                end
      endcase
    end
  end

  logica_condizioni u_cond (
    .clk       (clk),
    .rst_n     (rst_n),
    .cond      (Cond),
    .alu_flags (ALUFlags),
    .flag_w    (flag_w),
    .cond_ex   (cond_ex)
  );

  // A register write to r15 is a PC write
  assign pcs = (reg_w && (Rd == 4'hF)) || branch;

  // Enables are forced low while reset is held
  assign PCWrite   = rst_n & (next_pc | (pcs & cond_ex));
  assign RegWrite  = rst_n & reg_w & cond_ex;
  assign MemWrite  = rst_n & mem_w & cond_ex;
  assign IRWrite   = rst_n & ir_write;
  assign AdrSrc    = adr_src;
  assign ALUSrcA   = alu_src_a;
  assign ALUSrcB   = alu_src_b;
  assign ResultSrc = result_src;
  assign ImmSrc    = Op;
  assign RegSrc    = {(Op == OP_MEM), (Op == OP_BR)};

endmodule

// File: tb/tb_controllo_multiciclo.sv
// Directed bench for the multicycle controller.
module tb_controllo_multiciclo;
  import pkg_controllo::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl;

  int checks = 0;
  int errors = 0;

  controllo_multiciclo dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Cond       (Cond),
    .Op         (Op),
    .Funct      (Funct),
    .Rd         (Rd),
    .ALUFlags   (ALUFlags),
    .PCWrite    (PCWrite),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .IRWrite    (IRWrite),
    .AdrSrc     (AdrSrc),
    .ALUSrcA    (ALUSrcA),
    .ResultSrc  (ResultSrc),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc),
    .ALUControl (ALUControl)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                           input logic [3:0] r, input logic [3:0] af);
    Cond = c; Op = o; Funct = f; Rd = r; ALUFlags = af;
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    Cond = 4'b0000; Op = 2'b00; Funct = 6'b000000; Rd = 4'd0; ALUFlags = 4'b0000;
    #2;
    checks++; if (dut.state !== S_FETCH) begin errors++; $display("FAIL reset_state: got %0d want %0d", dut.state, S_FETCH); end
    checks++; if (PCWrite !== 1'b0) begin errors++; $display("FAIL reset_pcwrite: got %b want 0", PCWrite); end
    checks++; if (IRWrite !== 1'b0) begin errors++; $display("FAIL reset_irwrite: got %b want 0", IRWrite); end
    checks++; if ({RegWrite, MemWrite} !== 2'b00) begin errors++; $display("FAIL reset_writes: got %b want 00", {RegWrite, MemWrite}); end
    checks++; if ({ALUSrcA, ALUSrcB, ResultSrc} !== 5'b11010) begin errors++; $display("FAIL reset_fetch_decode: got %b want 11010", {ALUSrcA, ALUSrcB, ResultSrc}); end
    checks++; if (dut.u_cond.flags !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", dut.u_cond.flags); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if ({IRWrite, PCWrite} !== 2'b11) begin errors++; $display("FAIL release_fetch: got %b want 11", {IRWrite, PCWrite}); end
  endtask

  task automatic test_add;
    set_instr(4'b1110, 2'b00, 6'b001001, 4'd2, 4'b0100);
    step;
    checks++; if (dut.state !== S_DECODE) begin errors++; $display("FAIL add_decode: got %0d want %0d", dut.state, S_DECODE); end
    checks++; if ({IRWrite, PCWrite} !== 2'b00) begin errors++; $display("FAIL add_decode_en: got %b want 00", {IRWrite, PCWrite}); end
    step;
    checks++; if (dut.state !== S_EXECUTER) begin errors++; $display("FAIL add_exec: got %0d want %0d", dut.state, S_EXECUTER); end
    checks++; if ({ALUSrcB, ALUControl} !== 4'b0000) begin errors++; $display("FAIL add_exec_sel: got %b want 0000", {ALUSrcB, ALUControl}); end
    step;
    checks++; if (dut.state !== S_ALUWB) begin errors++; $display("FAIL add_aluwb: got %0d want %0d", dut.state, S_ALUWB); end
    checks++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL add_regwrite: got %b want 1", RegWrite); end
    checks++; if (dut.u_cond.flags !== 4'b0100) begin errors++; $display("FAIL add_flags: got %b want 0100", dut.u_cond.flags); end
    step;
    checks++; if (dut.state !== S_FETCH) begin errors++; $display("FAIL add_back_fetch: got %0d want %0d", dut.state, S_FETCH); end
  endtask

  task automatic test_undef_branch;
    set_instr(4'b1110, 2'b11, 6'b111111, 4'd15, 4'b1111);
    step;
    checks++; if (dut.state !== S_DECODE) begin errors++; $display("FAIL und_decode: got %0d want %0d", dut.state, S_DECODE); end
    checks++; if ({RegWrite, MemWrite} !== 2'b00) begin errors++; $display("FAIL und_writes: got %b want 00", {RegWrite, MemWrite}); end
    step;
    checks++; if (dut.state !== S_FETCH) begin errors++; $display("FAIL und_fetch: got %0d want %0d", dut.state, S_FETCH); end
    checks++; if (dut.u_cond.flags !== 4'b0100) begin errors++; $display("FAIL und_flags: got %b want 0100", dut.u_cond.flags); end
    // GT with Z=1 is not taken
    set_instr(4'b1100, 2'b10, 6'b100000, 4'd0, 4'b0000);
    step; step;
    checks++; if (dut.state !== S_BRANCH) begin errors++; $display("FAIL bgt_state: got %0d want %0d", dut.state, S_BRANCH); end
    checks++; if (PCWrite !== 1'b0) begin errors++; $display("FAIL bgt_pcwrite: got %b want 0", PCWrite); end
    checks++; if ({ImmSrc, RegSrc, ALUSrcB, ResultSrc} !== 8'b10010110) begin errors++; $display("FAIL bgt_sel: got %b want 10010110", {ImmSrc, RegSrc, ALUSrcB, ResultSrc}); end
    step;
    set_instr(4'b1110, 2'b10, 6'b100000, 4'd0, 4'b0000);
    step; step;
    checks++; if (PCWrite !== 1'b1) begin errors++; $display("FAIL bal_pcwrite: got %b want 1", PCWrite); end
    step;
  endtask

  task automatic test_cond_store;
    set_instr(4'b0001, 2'b01, 6'b011000, 4'd4, 4'b0000);
    checks++; if (PCWrite !== 1'b1) begin errors++; $display("FAIL ne_fetch_pc: got %b want 1", PCWrite); end
    step; step;
    checks++; if (dut.state !== S_MEMADR) begin errors++; $display("FAIL ne_memadr: got %0d want %0d", dut.state, S_MEMADR); end
    checks++; if ({ALUSrcB, ImmSrc, RegSrc} !== 6'b010110) begin errors++; $display("FAIL ne_sel: got %b want 010110", {ALUSrcB, ImmSrc, RegSrc}); end
    step;
    checks++; if (dut.state !== S_MEMWR) begin errors++; $display("FAIL ne_memwr: got %0d want %0d", dut.state, S_MEMWR); end
    checks++; if ({MemWrite, AdrSrc} !== 2'b01) begin errors++; $display("FAIL ne_memwrite: got %b want 01", {MemWrite, AdrSrc}); end
    step;
    set_instr(4'b0000, 2'b01, 6'b011000, 4'd4, 4'b0000);
    step; step; step;
    checks++; if (MemWrite !== 1'b1) begin errors++; $display("FAIL eq_memwrite: got %b want 1", MemWrite); end
    step;
  endtask

  task automatic test_ldr_pc;
    set_instr(4'b1110, 2'b01, 6'b011001, 4'd15, 4'b0000);
    checks++; if (PCWrite !== 1'b1) begin errors++; $display("FAIL ldr_fetch_pc: got %b want 1", PCWrite); end
    step;
    checks++; if (PCWrite !== 1'b0) begin errors++; $display("FAIL ldr_decode_pc: got %b want 0", PCWrite); end
    step; step;
    checks++; if (dut.state !== S_MEMRD) begin errors++; $display("FAIL ldr_memrd: got %0d want %0d", dut.state, S_MEMRD); end
    checks++; if ({PCWrite, RegWrite, AdrSrc} !== 3'b001) begin errors++; $display("FAIL ldr_memrd_out: got %b want 001", {PCWrite, RegWrite, AdrSrc}); end
    step;
    checks++; if (dut.state !== S_MEMWB) begin errors++; $display("FAIL ldr_memwb: got %0d want %0d", dut.state, S_MEMWB); end
    checks++; if ({PCWrite, RegWrite, ResultSrc} !== 4'b1101) begin errors++; $display("FAIL ldr_memwb_out: got %b want 1101", {PCWrite, RegWrite, ResultSrc}); end
    step;
    checks++; if (dut.state !== S_FETCH) begin errors++; $display("FAIL ldr_5cyc: got %0d want %0d", dut.state, S_FETCH); end
  endtask

  task automatic test_flag_update;
    // ORRS touches only N,Z
    set_instr(4'b1110, 2'b00, 6'b111001, 4'd3, 4'b1011);
    step; step;
    checks++; if (dut.state !== S_EXECUTEI) begin errors++; $display("FAIL orr_execi: got %0d want %0d", dut.state, S_EXECUTEI); end
    checks++; if ({ALUControl, ALUSrcB} !== 4'b1101) begin errors++; $display("FAIL orr_sel: got %b want 1101", {ALUControl, ALUSrcB}); end
    step;
    checks++; if (dut.u_cond.flags !== 4'b1000) begin errors++; $display("FAIL orr_flags: got %b want 1000", dut.u_cond.flags); end
    checks++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL orr_regwrite: got %b want 1", RegWrite); end
    step;
    // SUBS LT judged on N=1,V=0
    set_instr(4'b1011, 2'b00, 6'b000101, 4'd4, 4'b0010);
    step; step;
    checks++; if (ALUControl !== 2'b01) begin errors++; $display("FAIL subs_alu: got %b want 01", ALUControl); end
    step;
    checks++; if (dut.u_cond.flags !== 4'b0010) begin errors++; $display("FAIL subs_flags: got %b want 0010", dut.u_cond.flags); end
    step;
    // ANDS EQ with Z=0: fails, no write, flags hold
    set_instr(4'b0000, 2'b00, 6'b000001, 4'd5, 4'b1111);
    step; step;
    checks++; if (ALUControl !== 2'b10) begin errors++; $display("FAIL ands_alu: got %b want 10", ALUControl); end
    step;
    checks++; if (dut.state !== S_ALUWB) begin errors++; $display("FAIL ands_aluwb: got %0d want %0d", dut.state, S_ALUWB); end
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL ands_regwrite: got %b want 0", RegWrite); end
    checks++; if (dut.u_cond.flags !== 4'b0010) begin errors++; $display("FAIL ands_flags: got %b want 0010", dut.u_cond.flags); end
    step;
  endtask

  task automatic test_reset_mid;
    set_instr(4'b1110, 2'b01, 6'b011000, 4'd6, 4'b0000);
    step; step; step;
    checks++; if (MemWrite !== 1'b1) begin errors++; $display("FAIL mid_memwrite_pre: got %b want 1", MemWrite); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (dut.state !== S_FETCH) begin errors++; $display("FAIL mid_reset_state: got %0d want %0d", dut.state, S_FETCH); end
    checks++; if ({MemWrite, PCWrite, IRWrite} !== 3'b000) begin errors++; $display("FAIL mid_reset_en: got %b want 000", {MemWrite, PCWrite, IRWrite}); end
    checks++; if (dut.u_cond.flags !== 4'b0000) begin errors++; $display("FAIL mid_reset_flags: got %b want 0000", dut.u_cond.flags); end
    @(negedge clk);
    rst_n = 1'b1;
    step;
    checks++; if (dut.state !== S_DECODE) begin errors++; $display("FAIL mid_release: got %0d want %0d", dut.state, S_DECODE); end
  endtask

  initial begin
    test_reset;
    test_add;
    test_undef_branch;
    test_cond_store;
    test_ldr_pc;
    test_flag_update;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

endmodule
